// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit.
// One iteration per clock; result presented for one cycle after 32 iterations.
module multdiv_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [5:0]  count;
   logic        is_div;
   logic        neg;
   logic        div_zero;
   logic [31:0] opd;
   logic [31:0] hi;
   logic [31:0] lo;

   logic        start;
   logic [31:0] mag_a;
   logic [31:0] mag_b;

   logic [32:0] add_sum;
   logic [32:0] shifted;
   logic [33:0] diff;
   logic [31:0] hi_n;
   logic [31:0] lo_n;

   logic [63:0] prod_s;
   logic [31:0] quot_s;
   logic [31:0] res_n;
   logic        exc_n;

   assign start = ctrl_MULT | ctrl_DIV;

   // Operand magnitudes; 0x80000000 maps to 2^31 as an unsigned value
   always_comb begin
      mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
      mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
   end

   // One iteration: shift-add for multiply, restoring step for divide
   always_comb begin
      add_sum = {1'b0, hi} + {1'b0, (lo[0] ? opd : 32'd0)};
      shifted = {hi, lo[31]};
      diff    = {1'b0, shifted} - {2'b00, opd};
      if (is_div) begin
         hi_n = diff[33] ? shifted[31:0] : diff[31:0];
         lo_n = {lo[30:0], ~diff[33]};
      end else begin
         hi_n = add_sum[32:1];
         lo_n = {add_sum[0], lo[31:1]};
      end
   end

   // Re-apply the sign and derive the exception flag from the final step
   always_comb begin
      prod_s = neg ? (~{hi_n, lo_n} + 64'd1) : {hi_n, lo_n};
      quot_s = neg ? (~lo_n + 32'd1) : lo_n;
      if (is_div) begin
         if (div_zero) begin
            res_n = 32'd0;
            exc_n = 1'b1;
         end else begin
            res_n = quot_s;
            exc_n = ~neg & lo_n[31];
         end
      end else begin
         res_n = prod_s[31:0];
         exc_n = (prod_s[63:32] != {32{prod_s[31]}});
      end
   end

   // Control FSM and datapath registers; a new request always restarts
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         count          <= 6'd0;
         is_div         <= 1'b0;
         neg            <= 1'b0;
         div_zero       <= 1'b0;
         opd            <= 32'd0;
         hi             <= 32'd0;
         lo             <= 32'd0;
         data_result    <= 32'd0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (start) begin
            state    <= BUSY;
            count    <= 6'd0;
            is_div   <= ~ctrl_MULT;
            neg      <= data_operandA[31] ^ data_operandB[31];
            div_zero <= (data_operandB == 32'd0);
            hi       <= 32'd0;
            if (ctrl_MULT) begin
               opd <= mag_a;
               lo  <= mag_b;
            end else begin
               opd <= mag_b;
               lo  <= mag_a;
            end
         end else begin
            case (state)
               BUSY: begin
                  hi    <= hi_n;
                  lo    <= lo_n;
                  count <= count + 6'd1;
                  if (count == 6'd31) begin
                     state          <= DONE;
                     data_result    <= res_n;
                     data_exception <= exc_n;
                     data_resultRDY <= 1'b1;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed cases then random traffic,
// including aborts, back-to-back requests and asynchronous reset.
module tb_multdiv_unit;

   logic        clock;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] held_res = 32'd0;
   logic        held_exc = 1'b0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain signed arithmetic on 64-bit integers
   function automatic void model(input bit m, input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint p;
      if (m) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         p = longint'($signed(a)) / longint'($signed(b));
         r = p[31:0];
         e = 1'b0;
      end
   endfunction

   // Monitor: pops on every RDY, checks timing, value and hold stability
   always @(negedge clock) begin
      if (!reset) begin
         if (data_resultRDY) begin
            if (sb.size() == 0) begin
               chk("unexpected_rdy", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rdy_cycle", cyc, e.due);
               chk("result", data_result, e.res);
               chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
               held_res = e.res;
               held_exc = e.exc;
            end
         end else begin
            chk("hold_result", data_result, held_res);
            chk("hold_exc", {31'd0, data_exception}, {31'd0, held_exc});
            if (sb.size() > 0 && cyc >= sb[0].due) begin
               chk("missing_rdy", 32'd0, 32'd1);
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called just after a falling edge; request is sampled on the next edge
   task automatic issue(input bit m, input bit d, input logic [31:0] a,
                        input logic [31:0] b);
      exp_t        e;
      int          e0;
      logic [31:0] r;
      logic        x;
      e0 = cyc + 1;
      if (sb.size() > 0 && e0 <= sb[sb.size()-1].due)
         void'(sb.pop_back());
      model(m, a, b, r, x);
      e.res = r;
      e.exc = x;
      e.due = e0 + 32;
      sb.push_back(e);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   initial begin
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      idle(3);
      chk("reset_result", data_result, 32'd0);
      chk("reset_exc", {31'd0, data_exception}, 32'd0);
      chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
      ctrl_MULT = 1'b1;
      idle(1);
      ctrl_MULT = 1'b0;
      chk("reset_ignores_req", {31'd0, data_resultRDY}, 32'd0);
      reset = 1'b0;

      issue(1, 0, 32'd6, 32'd7);                     idle(40);
      issue(1, 0, -32'sd3, 32'd5);                   idle(40);
      issue(1, 0, 32'h0001_0000, 32'h0001_0000);     idle(40);
      issue(0, 1, 32'd7, -32'sd2);                   idle(40);
      issue(0, 1, -32'sd7, 32'd2);                   idle(40);
      issue(0, 1, 32'd5, 32'd0);                     idle(40);
      issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);     idle(40);
      issue(1, 0, 32'd6, 32'd7);                     idle(9);
      issue(0, 1, 32'd100, 32'd10);                  idle(40);
      issue(1, 1, 32'd9, 32'd3);                     idle(40);
      issue(1, 0, 32'h8000_0000, 32'h8000_0000);     idle(32);
      issue(0, 1, -32'sd100, 32'd7);                 idle(40);

      issue(1, 0, 32'd12345, 32'd678);
      idle(9);
      #2 reset = 1'b1;
      sb.delete();
      held_res = 32'd0;
      held_exc = 1'b0;
      #1;
      chk("async_reset_result", data_result, 32'd0);
      chk("async_reset_exc", {31'd0, data_exception}, 32'd0);
      chk("async_reset_rdy", {31'd0, data_resultRDY}, 32'd0);
      idle(3);
      reset = 1'b0;
      issue(1, 0, 32'd2, 32'd3);                     idle(40);

      for (int i = 0; i < 200; i++) begin
         bit          m;
         bit          d;
         logic [31:0] a;
         logic [31:0] b;
         m = 1'($urandom);
         d = ~m | 1'($urandom_range(0, 3) == 0);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: a = $urandom_range(0, 1000);
            2: b = 32'($urandom_range(1, 20)) - 32'd10;
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         issue(m, d, a, b);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 34));
         else idle($urandom_range(32, 36));
      end

      for (int t = 0; t < 100 && sb.size() > 0; t++) idle(1);
      if (sb.size() > 0) chk("drain_timeout", sb.size(), 32'd0);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL provide: clock  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high; forces idle state immediately.
REQ-003 SHALL provide: data_operandA  in  32  signed two's-complement multiplicand or dividend.
REQ-004 SHALL provide: data_operandB  in  32  signed two's-complement multiplier or divisor.
REQ-005 SHALL provide: ctrl_MULT  in  1  start-multiply request; one-cycle pulse from the processor execute stage.
REQ-006 SHALL provide: ctrl_DIV  in  1  start-divide request; one-cycle pulse.
REQ-007 SHALL provide: data_result  out  32  low 32 bits of the product, or the quotient.
REQ-008 SHALL provide: data_exception  out  1  overflow or divide-by-zero flag for the current result.
REQ-009 SHALL provide: data_resultRDY  out  1  result valid, asserted high for exactly one cycle.
REQ-010 SHALL use one clock, with reset asynchronous and active-high; port names are clock and reset.

Function
REQ-011 SHALL implement states IDLE, BUSY and DONE, plus a 6-bit iteration counter.
REQ-012 SHALL sample the operands and the request on the rising edge where ctrl_MULT or ctrl_DIV is high (edge E0), enter BUSY and clear the counter.
REQ-013 SHALL treat ctrl_MULT as having priority when both requests are high at the same edge; the operation is a multiply.
REQ-014 SHALL perform exactly one iteration per edge in BUSY: multiply is shift-add (or radix-2 Booth) on a 64-bit partial product; divide is restoring division on operand magnitudes.
REQ-015 SHALL move BUSY->DONE at edge E32, after 32 iterations, and drive data_resultRDY=1 only while in DONE, which spans E32 to E33.
REQ-016 SHALL move DONE->IDLE at E33 unless a new request is sampled at E33, in which case it enters BUSY (REQ-012).
REQ-017 SHALL abort the current operation on a new request sampled in BUSY and restart from E0 with the new operands; no RDY is issued for the aborted operation.
REQ-018 SHALL hold data_result and data_exception stable from E32 until the next E32; they are updated only on the BUSY->DONE transition.
REQ-019 SHALL, for multiply, set data_result to product[31:0] and data_exception=1 when product[63:32] is not all copies of product[31].
REQ-020 SHALL, for divide, truncate the quotient toward zero; the quotient sign is the XOR of the operand signs and the remainder is discarded.
REQ-021 SHALL, when divisor=0, produce data_result=0x00000000 and data_exception=1, still with 33-cycle timing.
REQ-022 SHALL, for 0x80000000 / 0xFFFFFFFF, produce data_result=0x80000000 and data_exception=1.
REQ-023 SHALL ignore requests while reset is high, and keep data_resultRDY low in IDLE and BUSY.
REQ-024 SHALL require 120-400 lines of RTL built from flops, adders and muxes; no behavioural * or / operators.

Reset
REQ-025 SHALL, while reset is high, force state=IDLE, counter=0, data_result=0, data_exception=0 and data_resultRDY=0, all asynchronously.
REQ-026 SHALL, on reset mid-BUSY, discard the operation; no RDY is issued, and the next request after reset deasserts behaves per REQ-012.

Verification
REQ-027 SHALL pass: MULT pulse with A=6, B=7 -> RDY high exactly the 33rd cycle after the request cycle, result=0x0000002A, exc=0.
REQ-028 SHALL pass: MULT A=-3, B=5 -> result=0xFFFFFFF1, exc=0; then MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exc=1.
REQ-029 SHALL pass: DIV A=7, B=-2 -> result=0xFFFFFFFD, exc=0; DIV A=-7, B=2 -> result=0xFFFFFFFD, exc=0.
REQ-030 SHALL pass: DIV A=5, B=0 -> result=0x00000000, exc=1, RDY on cycle 33; DIV 0x80000000 / -1 -> 0x80000000, exc=1.
REQ-031 SHALL pass: MULT 6x7, then DIV 100/10 issued 10 cycles later -> exactly one RDY, 33 cycles after the DIV, result=0x0000000A; MULT and DIV together -> multiply result.
REQ-032 SHALL pass: reset asserted 10 cycles into a MULT -> outputs 0 immediately and no RDY; a new MULT 2x3 afterwards -> 0x00000006 at cycle 33.
